// File: rtl/counter_pkg.sv
// Shared definitions for the counter / count_decoder family:
// decoder FSM states, mode encoding and the Johnson code table.
package counter_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic MODE_RING    = 1'b0;

  // Johnson nibble for each step index; entry [0] is the last element listed.
  localparam logic [7:0][3:0] JOHNSON_CODE = {
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

endpackage

// File: rtl/count_decoder_code_lookup.sv
// code_lookup: combinational decode of a counter code word into a step
// index plus a legality flag. Johnson mode looks at code[7:4] only; ring
// mode requires exactly one bit set in code[7:0].
module code_lookup
  import counter_pkg::*;
(
  input  logic [7:0] code,
  input  logic       mode,
  output logic [2:0] index,
  output logic       legal
);

  logic [3:0] ones;

  // Table match for Johnson, set-bit position and population count for ring.
  always_comb begin
    index = '0;
    legal = 1'b0;
    ones  = '0;
    if (mode == MODE_JOHNSON) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (code[7:4] == JOHNSON_CODE[3'(i)]) begin
          index = 3'(i);
          legal = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (code[3'(i)]) begin
          index = 3'(i);
          ones  = ones + 4'd1;
        end
      end
      legal = (ones == 4'd1);
    end
  end

endmodule

// File: rtl/count_decoder.sv
// count_decoder: receive-side checker for the Johnson/ring counter.
// Decodes each valid sample, tracks the expected successor and reports
// lock, illegal code words and out-of-sequence steps. All outputs are
// registered. Optional saturating error counter: COUNT_DECODER_ERRCNT_EN.
module count_decoder
  import counter_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 2
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       mode,
  input  logic       valid_in,
  output logic [2:0] index,
  output logic       index_valid,
  output logic       locked,
  output logic       illegal,
  output logic       seq_err
`ifdef COUNT_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  state_t     state_q, state_d, cur_state;
  logic [2:0] prev_q, prev_d;
  logic [2:0] run_q, run_d, run_inc;
  logic       mode_q, mode_d;
  logic       ill_d, seq_d;
  logic       locked_q, illegal_q, seq_err_q;
  logic [2:0] lk_index;
  logic       lk_legal;
  logic       is_succ, is_hold;

  code_lookup u_lookup (
    .code  (code_in),
    .mode  (mode),
    .index (lk_index),
    .legal (lk_legal)
  );

  assign is_succ = (lk_index == prev_q + 3'd1);
  assign is_hold = (lk_index == prev_q);
  assign run_inc = run_q + 3'd1;

  // Next-state, tracked index, run length and error pulses.
  // A mode change is folded in by evaluating the sample as if in HUNT.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    mode_d    = mode_q;
    ill_d     = 1'b0;
    seq_d     = 1'b0;
    cur_state = state_q;
    if (valid_in) begin
      mode_d = mode;
      if (mode != mode_q) begin
        cur_state = HUNT;
      end
      if (!lk_legal) begin
        ill_d   = 1'b1;
        state_d = HUNT;
        run_d   = '0;
      end else begin
        case (cur_state)
          HUNT: begin
            state_d = CONFIRM;
            prev_d  = lk_index;
            run_d   = 3'd1;
          end
          CONFIRM: begin
            if (is_succ) begin
              prev_d = lk_index;
              run_d  = run_inc;
              if (run_inc == 3'(LOCK_CNT)) begin
                state_d = LOCKED;
              end
            end else if (!is_hold) begin
              prev_d = lk_index;
              run_d  = 3'd1;
            end
          end
          LOCKED: begin
            if (is_succ || is_hold) begin
              prev_d = lk_index;
            end else begin
              seq_d   = 1'b1;
              state_d = HUNT;
              run_d   = '0;
            end
          end
          default: begin
            state_d = HUNT;
            run_d   = '0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      prev_q    <= '0;
      run_q     <= '0;
      mode_q    <= MODE_RING;
      locked_q  <= 1'b0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      locked_q  <= (state_d == LOCKED);
      illegal_q <= ill_d;
      seq_err_q <= seq_d;
    end
  end

  assign index       = prev_q;
  assign index_valid = locked_q;
  assign locked      = locked_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;

`ifdef COUNT_DECODER_ERRCNT_EN
  logic [7:0] err_q;

  // Saturating count of error pulses, updated alongside the pulse itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if ((ill_d || seq_d) && (err_q != '1)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule
